// File: rtl/delay_responder.sv
// Responder for the req |-> ##[MIN_DLY:MAX_DLY] ack window protocol, with stall and fault injection.
// Define DELAY_RESPONDER_CHECK_EN to compile the embedded protocol assertions and cover.
module delay_responder #(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             hold,
  input  logic             block,
  output logic             ack,
  output logic [3:0]       pending,
  output logic             miss,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] ack_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  // pend_q[k] set: a request accepted k cycles ago is still unserved.
  logic [MAX_DLY:1] pend_q, pend_d;
  logic [MAX_DLY:1] win_vec;
  logic             win;
  logic             drop;
  logic             miss_q;
  logic [CNT_W-1:0] req_cnt_q, ack_cnt_q, miss_cnt_q;

  for (genvar k = 1; k <= MAX_DLY; k++) begin : g_age
    if (k >= MIN_DLY) begin : g_win
      assign win_vec[k] = pend_q[k];
    end else begin : g_young
      assign win_vec[k] = 1'b0;
    end

    // A single ack retires every entry inside the window; younger entries just age.
    if (k == 1) begin : g_head
      assign pend_d[k] = req;
    end else if (k - 1 >= MIN_DLY) begin : g_retire
      assign pend_d[k] = pend_q[k-1] & ~ack;
    end else begin : g_shift
      assign pend_d[k] = pend_q[k-1];
    end
  end

  assign win  = |win_vec;
  // Hold yields at the deadline; block never does. Reset forces ack low.
  assign ack  = ~reset & win & ~block & (~hold | pend_q[MAX_DLY]);
  assign drop = pend_q[MAX_DLY] & ~ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q     <= '0;
      miss_q     <= 1'b0;
      req_cnt_q  <= '0;
      ack_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      if (drop) begin
        miss_q <= 1'b1;
      end
      if (req && (req_cnt_q != '1)) begin
        req_cnt_q <= req_cnt_q + CNT_W'(1);
      end
      if (ack && (ack_cnt_q != '1)) begin
        ack_cnt_q <= ack_cnt_q + CNT_W'(1);
      end
      if (drop && (miss_cnt_q != '1)) begin
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pending  = 4'($countones(pend_q));
  assign miss     = miss_q;
  assign req_cnt  = req_cnt_q;
  assign ack_cnt  = ack_cnt_q;
  assign miss_cnt = miss_cnt_q;

`ifdef DELAY_RESPONDER_CHECK_EN
  default clocking cb @(posedge clock);
  endclocking
  default disable iff (reset);

  // A blocked deadline is the only legal way to go without an ack.
  ap_window : assert property (req |-> ##[MIN_DLY:MAX_DLY] (ack || block));

  ap_miss_needs_block : assert property (
    ($changed(miss_cnt) && $past(!reset)) |-> $past(block));

  cp_ack_under_hold : cover property (ack && hold);
`else
  // Checks compiled out; port behaviour is unchanged.
`endif

endmodule
